shift_cmd_pipe: RTL

Buffered command front-end for the 4-bit combinational barrel shifter. Accepts shift commands {data, direction, amount} over a valid/ready handshake and queues them in a small FIFO. Issues each command to the `shift_left_right` datapath and registers the result behind an output valid/ready handshake. Sits between the command producer and any downstream result consumer, decoupling both from the shifter's combinational path.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_left_right.sv | 13 +
 rtl/shift_cmd_pipe.sv | 109 ++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared constants for the shift command pipe: direction encodings, field widths and
// the bit layout of a queued command word {data, dir, num}.
package shift_pkg;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned SHIFT_W = 4;
  localparam int unsigned NUM_W   = 2;
  localparam int unsigned CMD_W   = SHIFT_W + 1 + NUM_W;

  localparam int unsigned CMD_NUM_LSB  = 0;
  localparam int unsigned CMD_DIR_BIT  = NUM_W;
  localparam int unsigned CMD_DATA_LSB = NUM_W + 1;

  function automatic logic [CMD_W-1:0] pack_cmd(input logic [SHIFT_W-1:0] data,
                                                 input logic              dir,
                                                 input logic [NUM_W-1:0]   num);
    return {data, dir, num};
  endfunction

endpackage

// File: rtl/shift_left_right.sv
// 4-bit combinational logical barrel shifter, zero-fill in both directions.
module shift_left_right
  import shift_pkg::*;
(
  input  logic [SHIFT_W-1:0] in,
  input  logic               dir,
  input  logic [NUM_W-1:0]   num,
  output logic [SHIFT_W-1:0] out
);

  assign out = (dir == DIR_RIGHT) ? (in >> num) : (in << num);

endmodule

// File: rtl/shift_cmd_pipe.sv
// Command FIFO in front of shift_left_right with a registered valid/ready result stage.
// Optional completed-result counter port ops_cnt when SHIFT_OPS_CNT_EN is defined.
module shift_cmd_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [NUM_W-1:0] in_num,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SHIFT_OPS_CNT_EN
  ,
  output logic [7:0]       ops_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [CMD_W-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               push, issue;
  logic [CMD_W-1:0]   head;
  logic [SHIFT_W-1:0] shift_res;

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready = (count_q != CntW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign issue    = (count_q != '0) && (!out_valid_q || out_ready);
  assign head     = mem_q[rd_ptr_q];

  shift_left_right u_shift (
    .in  (head[CMD_DATA_LSB +: SHIFT_W]),
    .dir (head[CMD_DIR_BIT]),
    .num (head[CMD_NUM_LSB +: NUM_W]),
    .out (shift_res)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (issue) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !issue) begin
      count_d = count_q + CntW'(1);
    end else if (!push && issue) begin
      count_d = count_q - CntW'(1);
    end
    if (issue) begin
      out_valid_d = 1'b1;
      out_data_d  = shift_res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Storage is not reset; only pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pack_cmd(in_data, in_dir, in_num);
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef SHIFT_OPS_CNT_EN
  logic [7:0] ops_cnt_q, ops_cnt_d;

  assign ops_cnt_d = (out_valid_q && out_ready) ? ops_cnt_q + 8'd1 : ops_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) ops_cnt_q <= '0;
    else        ops_cnt_q <= ops_cnt_d;
  end

  assign ops_cnt = ops_cnt_q;
`endif

endmodule
